// File: rtl/raster_pkg.sv
// Shared definitions for the raster scan generator / capture pair.
package raster_pkg;
    localparam int RASTER_W = 16;
    localparam int RASTER_H = 16;

    typedef logic [3:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;
endpackage

// File: rtl/raster_fb.sv
// Frame buffer: one write port, one registered read port (read-before-write).
module raster_fb #(
    parameter int DEPTH = 256,
    parameter int PIX_W = 8,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    input  logic             rd_ok,
    output logic [PIX_W-1:0] rd_data
);
    logic [PIX_W-1:0] mem [DEPTH];

    // Pixel storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read; a same-cycle write to the same address is not visible yet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data <= '0;
        else        rd_data <= rd_ok ? mem[rd_addr] : '0;
    end
endmodule

// File: rtl/raster_capture.sv
// Raster stream capture: tracks scan position, checks SOF/EOL markers,
// stores pixels into a frame buffer and holds the frame until acknowledged.
module raster_capture
    import raster_pkg::*;
#(
    parameter int WIDTH  = RASTER_W,
    parameter int HEIGHT = RASTER_H,
    parameter int PIX_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_sof,
    input  logic             in_eol,
    output logic [3:0]       x,
    output logic [3:0]       y,
    output logic             frame_done,
    input  logic             frame_ack,
    output logic             sync_err,
    input  logic             clear_err,
    input  logic [3:0]       rd_x,
    input  logic [3:0]       rd_y,
    output logic [PIX_W-1:0] rd_data
);
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int AW = $clog2(WIDTH * HEIGHT);
    localparam coord_t X_LAST = coord_t'(WIDTH - 1);
    localparam coord_t Y_LAST = coord_t'(HEIGHT - 1);

    state_t        state, state_nx;
    coord_t        x_nx, y_nx;
    logic          xfer, wr_en, err_set, done_set, rd_ok;
    logic [AW-1:0] wr_addr, rd_addr;

    assign in_ready = (state != DONE);
    assign xfer     = in_valid && in_ready;
    assign rd_addr  = AW'(int'(rd_y) * WIDTH + int'(rd_x));
    assign rd_ok    = ((32'(rd_x) >> XW) == 32'd0) && ((32'(rd_y) >> YW) == 32'd0);

    // Next position, state, write strobe and marker checks for the current beat.
    always_comb begin
        state_nx = state;
        x_nx     = x;
        y_nx     = y;
        wr_en    = 1'b0;
        wr_addr  = AW'(int'(y) * WIDTH + int'(x));
        err_set  = 1'b0;
        done_set = 1'b0;
        case (state)
            IDLE: begin
                // Only an SOF beat starts a frame; anything else is dropped silently.
                if (xfer && in_sof) begin
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    x_nx     = coord_t'(1);
                    y_nx     = '0;
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (in_sof) begin
                        // SOF always re-anchors the frame at the origin.
                        wr_addr = '0;
                        x_nx    = coord_t'(1);
                        y_nx    = '0;
                        err_set = (x != '0) || (y != '0);
                    end else begin
                        err_set = in_eol != (x == X_LAST);
                        if (in_eol || x == X_LAST) begin
                            x_nx = '0;
                            if (y == Y_LAST) begin
                                y_nx     = '0;
                                state_nx = DONE;
                                done_set = 1'b1;
                            end else begin
                                y_nx = y + 4'd1;
                            end
                        end else begin
                            x_nx = x + 4'd1;
                        end
                    end
                end
            end
            DONE: begin
                if (frame_ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, position, done pulse and sticky error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            x          <= x_nx;
            y          <= y_nx;
            frame_done <= done_set;
            if (err_set)        sync_err <= 1'b1;
            else if (clear_err) sync_err <= 1'b0;
        end
    end

    raster_fb #(
        .DEPTH (WIDTH * HEIGHT),
        .PIX_W (PIX_W),
        .AW    (AW)
    ) u_fb (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_ok   (rd_ok),
        .rd_data (rd_data)
    );
endmodule

// File: doc/raster_capture.md
Name: raster_capture

Overview:
- Receiving end of the raster scan: consumes a pixel stream ordered by the raster generator's scan (x fastest, then y).
- Tracks the current (x, y) position and stores each pixel into an internal WIDTH x HEIGHT frame buffer.
- Checks the stream's start-of-frame and end-of-line markers against the tracked position.
- Holds a completed frame until the downstream reader acknowledges it.

Parameters:
- WIDTH, 16, pixels per line; power of two, max 16.
- HEIGHT, 16, lines per frame; power of two, max 16.
- PIX_W, 8, pixel data width in bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  pixel beat valid.
- in_ready  out  1  capture accepts a beat. A beat transfers when in_valid and in_ready are both 1 at a rising edge.
- in_data  in  PIX_W  pixel value.
- in_sof  in  1  beat is pixel (0,0) of a frame.
- in_eol  in  1  beat is the last pixel of its line.
- x  out  4  column the next accepted beat is written to.
- y  out  4  row the next accepted beat is written to.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame has been written.
- frame_ack  in  1  reader releases the held frame.
- sync_err  out  1  sticky marker-mismatch flag.
- clear_err  in  1  synchronous clear of sync_err.
- rd_x  in  4  read column.
- rd_y  in  4  read row.
- rd_data  out  PIX_W  buffer[rd_y][rd_x], registered with 1-cycle latency.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; x=0, y=0, frame_done=0, sync_err=0, rd_data=0.
  - in_ready is 1 after reset release.
  - Buffer contents are not reset.
- IDLE (in_ready=1):
  - Accepted beats with in_sof=0 are discarded; x and y stay 0; no error is flagged.
  - An accepted beat with in_sof=1 writes buffer[0][0], then x=1, y=0, and the state moves to CAPTURE.
- CAPTURE (in_ready=1): each accepted beat writes buffer[y][x].
  - Normal end of line: x=WIDTH-1 with in_eol=1 gives x=0, y=y+1.
  - Early end of line: in_eol=1 with x<WIDTH-1 sets sync_err. The line is truncated (x=0, y=y+1); unwritten pixels keep their old contents.
  - Missing end of line: x=WIDTH-1 with in_eol=0 sets sync_err; the position still wraps to x=0, y=y+1.
  - Mid-frame SOF: in_sof=1 at any position other than (0,0) sets sync_err. The beat is written to (0,0), then x=1, y=0; the frame restarts.
  - Frame end: the beat at (WIDTH-1, HEIGHT-1), or any end of line on row HEIGHT-1, moves the state to DONE. frame_done=1 in the following cycle only; x=0, y=0.
- DONE (in_ready=0):
  - No beats are accepted.
  - frame_ack=1 returns the state to IDLE on the next edge; in_ready=1 from that cycle.
  - frame_ack outside DONE is ignored.
- Read port:
  - rd_data <= buffer[rd_y][rd_x] every cycle, in any state.
  - If a write and a read hit the same address in the same cycle, rd_data returns the old value.
  - Out-of-range rd_x/rd_y (>= WIDTH/HEIGHT) return 0.
- sync_err:
  - Set has priority over clear_err in the same cycle.
  - Holds through DONE and IDLE until cleared or reset.
- Reset mid-frame: state returns to IDLE at once and the partial frame is abandoned.
- Address arithmetic: addr = y*WIDTH + x, clog2(WIDTH*HEIGHT) bits wide. x and y are zero-extended to 4 bits on the ports.

Decomposition:
- Shared package raster_pkg: state enum (IDLE, CAPTURE, DONE), RASTER_W=16, RASTER_H=16, and a coord_t 4-bit typedef shared with the raster generator.
- One sub-module, raster_fb: simple dual-port memory with one write port and one registered read port, sized WIDTH*HEIGHT x PIX_W.
- Position tracking and the state machine live in raster_capture.

Test Plan:
- Reset, then 256 clean beats (data=y*16+x, sof on the first beat, eol every 16th beat):
  - frame_done pulses exactly once, one cycle after beat 256.
  - sync_err=0; in_ready=0 afterwards.
  - Read (3,5) returns 0x53 one cycle after rd_x/rd_y are applied.
- 5 beats with in_sof=0 while in IDLE, then a clean frame: the first 5 beats are discarded; x=0, y=0 until the SOF beat; the frame is captured correctly.
- in_eol asserted at x=9, y=2: sync_err=1; next beat writes (0,3).
  - Then clear_err=1 for one cycle: sync_err=0.
- in_sof asserted at x=4, y=7: sync_err=1; that beat lands at (0,0); x=1, y=0 afterwards.
- Frame complete with in_valid held at 1 for 3 cycles before frame_ack: no transfers, in_ready=0.
  - frame_ack pulse: in_ready=1 on the next cycle; IDLE awaits SOF.
- reset=0 asserted asynchronously between edges at x=6, y=10: x, y, frame_done and sync_err go to 0 immediately; state is IDLE after release.
